// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional BIN2BCD_AUTO_START_EN: re-convert automatically whenever bin_i changes.
module bin2bcd_seq #(
  parameter int unsigned BIN_WIDTH = 16,
  parameter int unsigned DIGITS    = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [BIN_WIDTH-1:0]  bin_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  overflow_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

  function automatic longint unsigned max_dec(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

  localparam longint unsigned MaxVal = max_dec(DIGITS);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
  logic [BcdW-1:0]      scratch_q, scratch_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ovf_cap_q, ovf_cap_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;

  logic                 start_fire;
  logic [BcdW-1:0]      adj;
  logic [BcdW-1:0]      scratch_nxt;

`ifdef BIN2BCD_AUTO_START_EN
  logic [BIN_WIDTH-1:0] last_bin_q, last_bin_d;
  logic                 last_valid_q, last_valid_d;
  logic                 unused_start_i;

  assign unused_start_i = start_i;
  assign start_fire     = !last_valid_q || (bin_i != last_bin_q);

  always_comb begin
    last_bin_d   = last_bin_q;
    last_valid_d = last_valid_q;
    if (state_q == StIdle && start_fire) begin
      last_bin_d   = bin_i;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_bin_q   <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_bin_q   <= last_bin_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  assign start_fire = start_i;
`endif

  // Add-3 correction on every digit at once, ahead of the shift.
  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_nxt = {adj[BcdW-2:0], shreg_q[BIN_WIDTH-1]};
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_cap_d = ovf_cap_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_fire) begin
          state_d   = StShift;
          shreg_d   = bin_i;
          scratch_d = '0;
          cnt_d     = CntW'(BIN_WIDTH);
          ovf_cap_d = 64'(bin_i) > MaxVal;
          busy_d    = 1'b1;
        end
      end
      StShift: begin
        scratch_d = scratch_nxt;
        shreg_d   = {shreg_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CntW'(1);
        // Outputs are registered, so they load on the edge that enters DONE.
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          bcd_d   = ovf_cap_q ? {DIGITS{4'h9}} : scratch_nxt;
          ovf_d   = ovf_cap_q;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_cap_q <= ovf_cap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign bcd_o      = bcd_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Table-driven bench for bin2bcd_seq: a 5-digit and a 2-digit instance share stimulus.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bin;
  logic        start;
  logic        busy, done, ovf;
  logic [19:0] bcd;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(5)) dut (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .bin_i      (bin),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .bcd_o      (bcd),
    .overflow_o (ovf)
  );

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(2)) dut2 (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .bin_i      (bin),
    .start_i    (start),
    .busy_o     (busy2),
    .done_o     (done2),
    .bcd_o      (bcd2),
    .overflow_o (ovf2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_bcd2(input logic [15:0] v);
    if (v > 16'd99) return 8'h99;
    return {4'(v / 16'd10), 4'(v % 16'd10)};
  endfunction

  task automatic check_dut2(input string tag, input logic [15:0] v);
    check($sformatf("%s d2 done", tag), 32'(done2), 32'd1);
    check($sformatf("%s d2 bcd", tag), 32'(bcd2), 32'(exp_bcd2(v)));
    check($sformatf("%s d2 ovf", tag), 32'(ovf2), 32'(v > 16'd99));
  endtask

  task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd);
    int    lat;
    bit    busy_ok;
    string tag;
    tag = $sformatf("conv %0d", v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd17);
    check({tag, " busy"}, 32'(busy_ok), 32'd1);
    check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, " ovf"}, 32'(ovf), 32'd0);
    check_dut2(tag, v);
    @(negedge clk);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle done"}, 32'(done), 32'd0);
  endtask

  task automatic count_done(input int ncyc, output int n, output logic [19:0] last);
    n    = 0;
    last = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done) begin
        n++;
        last = bcd;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [19:0] last;

    vecs[0] = '{16'd255,   20'h00255};
    vecs[1] = '{16'hFFFF,  20'h65535};
    vecs[2] = '{16'd0,     20'h00000};
    vecs[3] = '{16'd1234,  20'h01234};
    vecs[4] = '{16'd9999,  20'h09999};
    vecs[5] = '{16'd10000, 20'h10000};
    vecs[6] = '{16'd42,    20'h00042};
    vecs[7] = '{16'd59049, 20'h59049};
    vecs[8] = '{16'd100,   20'h00100};
    vecs[9] = '{16'd99,    20'h00099};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = 16'd500;
    repeat (3) @(negedge clk);
    check("reset bcd", 32'(bcd), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);

`ifdef BIN2BCD_AUTO_START_EN
    rst_n = 1'b1;
    count_done(40, n, last);
    check("auto first count", 32'(n), 32'd1);
    check("auto first bcd", 32'(last), 32'h00500);
    check("auto d2 bcd", 32'(bcd2), 32'h99);
    check("auto d2 ovf", 32'(ovf2), 32'd1);
    count_done(100, n, last);
    check("auto steady count", 32'(n), 32'd0);
    bin = 16'd501;
    count_done(40, n, last);
    check("auto change count", 32'(n), 32'd1);
    check("auto change bcd", 32'(last), 32'h00501);
`else
    rst_n = 1'b1;
    count_done(5, n, last);
    check("no spontaneous start", 32'(n), 32'd0);

    for (int i = 0; i < 10; i++) convert(vecs[i].bin, vecs[i].bcd);

    // A start pulse during SHIFT with a new bin_i must be dropped.
    @(negedge clk);
    bin   = 16'd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin   = 16'd42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_done(40, n, last);
    check("ignore start count", 32'(n), 32'd1);
    check("ignore start bcd", 32'(last), 32'h01234);
    check("ignore start hold", 32'(bcd), 32'h01234);
    check("ignore start d2 bcd", 32'(bcd2), 32'h99);
    check("ignore start d2 ovf", 32'(ovf2), 32'd1);

    // Asynchronous reset at cycle 8 of a conversion.
    @(negedge clk);
    bin   = 16'd9999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset bcd", 32'(bcd), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset ovf", 32'(ovf), 32'd0);
    check("midreset d2 bcd", 32'(bcd2), 32'd0);
    check("midreset d2 ovf", 32'(ovf2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(20, n, last);
    check("post reset no done", 32'(n), 32'd0);
    convert(16'd7, 20'h00007);
    repeat (5) @(negedge clk);
    check("hold bcd", 32'(bcd), 32'h00007);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
